// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared types and defaults for the program-counter sequencer
package pc_pkg;

    localparam int PC_D_DEFAULT        = 12;
    localparam int PC_START_PC_DEFAULT = 0;
    localparam int LUT_IDX_W           = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_t;

endpackage

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch-path PC sequencer with run/halt handshake; optional LAST_BR_EN adds Last_br_pc
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int             D        = PC_D_DEFAULT,
    parameter logic [D-1:0]   START_PC = D'(PC_START_PC_DEFAULT),
    parameter int             CNT_W    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic                 Stall,
    input  logic                 Halt_req,
    input  logic                 Br_en,
    input  logic                 Br_abs,
    input  logic [LUT_IDX_W-1:0] Br_idx,
    output logic [LUT_IDX_W-1:0] Lut_idx,
    input  logic [D-1:0]         Target,
    output logic [D-1:0]         PC,
`ifdef LAST_BR_EN
    output logic [D-1:0]         Last_br_pc,
`endif
    output logic                 Running,
    output logic                 Done,
    output logic [CNT_W-1:0]     Cycles
);

    pc_state_t        state;
    logic [CNT_W-1:0] cycles_next;
    logic [D-1:0]     branch_pc;

    // The LUT is combinational, so the index passes straight through and Target returns in the same cycle
    assign Lut_idx = Br_idx;

    // Retired-cycle count sticks at all-ones rather than wrapping back to zero
    assign cycles_next = (&Cycles) ? Cycles : Cycles + CNT_W'(1);

    // Relative targets are two's complement, so a plain D-bit add with the carry dropped covers back-branches
    assign branch_pc = Br_abs ? Target : PC + Target;

    // Run/halt FSM and PC datapath; Running and Done are registered copies of the next state
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            PC         <= START_PC;
            Cycles     <= '0;
            Running    <= 1'b0;
            Done       <= 1'b0;
`ifdef LAST_BR_EN
            Last_br_pc <= '0;
`endif
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (Start) begin
                        state      <= RUN;
                        PC         <= START_PC;
                        Cycles     <= '0;
                        Running    <= 1'b1;
                        Done       <= 1'b0;
`ifdef LAST_BR_EN
                        Last_br_pc <= '0;
`endif
                    end
                end
                RUN: begin
                    // A stalled cycle retires nothing, so halt and branch requests wait for a clean cycle
                    if (!Stall) begin
                        Cycles <= cycles_next;
                        if (Halt_req) begin
                            state   <= HALT;
                            Running <= 1'b0;
                            Done    <= 1'b1;
                        end else if (Br_en) begin
                            PC         <= branch_pc;
`ifdef LAST_BR_EN
                            Last_br_pc <= PC;
`endif
                        end else begin
                            PC <= PC + D'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    Running <= 1'b0;
                    Done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer with directed vectors
module tb_pc_sequencer;
    import pc_pkg::*;

    localparam int D     = 12;
    localparam int CNT_W = 4;

    logic                 Clk = 1'b0;
    logic                 Reset, Start, Stall, Halt_req, Br_en, Br_abs;
    logic [LUT_IDX_W-1:0] Br_idx, Lut_idx;
    logic [D-1:0]         Target, PC;
    logic                 Running, Done;
    logic [CNT_W-1:0]     Cycles;
`ifdef LAST_BR_EN
    logic [D-1:0]         Last_br_pc;
`endif

    typedef struct {
        string            name;
        logic [D-1:0]     pc;
        logic [CNT_W-1:0] cyc;
        logic             run;
        logic             done;
        logic [LUT_IDX_W-1:0] idx;
        logic [D-1:0]     last;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_fail = 0;
    bit   stim_done = 1'b0;

    pc_sequencer #(.D(D), .START_PC(12'd0), .CNT_W(CNT_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Start    (Start),
        .Stall    (Stall),
        .Halt_req (Halt_req),
        .Br_en    (Br_en),
        .Br_abs   (Br_abs),
        .Br_idx   (Br_idx),
        .Lut_idx  (Lut_idx),
        .Target   (Target),
        .PC       (PC),
`ifdef LAST_BR_EN
        .Last_br_pc (Last_br_pc),
`endif
        .Running  (Running),
        .Done     (Done),
        .Cycles   (Cycles)
    );

    always #5 Clk = ~Clk;

    // Drive one cycle of inputs at the falling edge and queue the state expected after the next rising edge
    task automatic step(input string name, input logic rst, input logic st, input logic stl,
                        input logic hlt, input logic br, input logic ab,
                        input logic [LUT_IDX_W-1:0] idx, input logic [D-1:0] tgt,
                        input logic [D-1:0] e_pc, input logic [CNT_W-1:0] e_cyc,
                        input logic e_run, input logic e_done, input logic [D-1:0] e_last);
        exp_t e;
        @(negedge Clk);
        Reset = rst; Start = st; Stall = stl; Halt_req = hlt;
        Br_en = br; Br_abs = ab; Br_idx = idx; Target = tgt;
        e.name = name; e.pc = e_pc; e.cyc = e_cyc; e.run = e_run;
        e.done = e_done; e.idx = idx; e.last = e_last;
        exp_q.push_back(e);
        @(posedge Clk);
    endtask

    // Monitor: pop one expectation per rising edge and compare each observable
    always begin
        exp_t e;
        @(posedge Clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (PC !== e.pc) begin
                n_fail++; $display("FAIL %s pc: got %h want %h", e.name, PC, e.pc);
            end
            if (Cycles !== e.cyc) begin
                n_fail++; $display("FAIL %s cycles: got %0d want %0d", e.name, Cycles, e.cyc);
            end
            if (Running !== e.run) begin
                n_fail++; $display("FAIL %s running: got %b want %b", e.name, Running, e.run);
            end
            if (Done !== e.done) begin
                n_fail++; $display("FAIL %s done: got %b want %b", e.name, Done, e.done);
            end
            if (Lut_idx !== e.idx) begin
                n_fail++; $display("FAIL %s lut_idx: got %0d want %0d", e.name, Lut_idx, e.idx);
            end
`ifdef LAST_BR_EN
            if (Last_br_pc !== e.last) begin
                n_fail++; $display("FAIL %s last_br_pc: got %h want %h", e.name, Last_br_pc, e.last);
            end
`endif
        end
    end

    initial begin
        Reset = 1'b1; Start = 1'b0; Stall = 1'b0; Halt_req = 1'b0;
        Br_en = 1'b0; Br_abs = 1'b0; Br_idx = '0; Target = '0;
        //    name          rst st  stl hlt br  abs idx   target    pc        cyc  run done last
        step("reset",       1, 0, 0, 0, 0, 0, 3'd0, 12'h000, 12'd0,   4'd0, 0, 0, 12'd0);
        step("idle_hold",   0, 0, 0, 0, 1, 1, 3'd1, 12'h055, 12'd0,   4'd0, 0, 0, 12'd0);
        step("start",       0, 1, 0, 0, 0, 0, 3'd2, 12'h000, 12'd0,   4'd0, 1, 0, 12'd0);
        step("plain1",      0, 0, 0, 0, 0, 0, 3'd0, 12'h000, 12'd1,   4'd1, 1, 0, 12'd0);
        step("plain2",      0, 0, 0, 0, 0, 0, 3'd0, 12'h000, 12'd2,   4'd2, 1, 0, 12'd0);
        step("plain3",      0, 1, 0, 0, 0, 0, 3'd0, 12'h000, 12'd3,   4'd3, 1, 0, 12'd0);
        step("abs40",       0, 0, 0, 0, 1, 1, 3'd3, 12'd40,  12'd40,  4'd4, 1, 0, 12'd3);
        step("rel_m30",     0, 0, 0, 0, 1, 0, 3'd4, 12'hFE2, 12'd10,  4'd5, 1, 0, 12'd40);
        step("abs4",        0, 0, 0, 0, 1, 1, 3'd5, 12'd4,   12'd4,   4'd6, 1, 0, 12'd10);
        step("rel_m1",      0, 0, 0, 0, 1, 0, 3'd6, 12'hFFF, 12'd3,   4'd7, 1, 0, 12'd4);
        step("abs346",      0, 0, 0, 0, 1, 1, 3'd7, 12'd346, 12'd346, 4'd8, 1, 0, 12'd3);
        step("abs_fff",     0, 0, 0, 0, 1, 1, 3'd1, 12'hFFF, 12'hFFF, 4'd9, 1, 0, 12'd346);
        step("wrap",        0, 0, 0, 0, 0, 0, 3'd0, 12'h000, 12'd0,   4'd10, 1, 0, 12'd346);
        step("rel_m5",      0, 0, 0, 0, 1, 0, 3'd2, 12'hFFB, 12'hFFB, 4'd11, 1, 0, 12'd0);
        step("stall_all",   0, 1, 1, 1, 1, 1, 3'd3, 12'h123, 12'hFFB, 4'd11, 1, 0, 12'd0);
        step("halt_br",     0, 0, 0, 1, 1, 1, 3'd4, 12'h123, 12'hFFB, 4'd12, 0, 1, 12'd0);
        step("halt_hold",   0, 0, 0, 0, 1, 1, 3'd5, 12'h123, 12'hFFB, 4'd12, 0, 1, 12'd0);
        step("restart",     0, 1, 0, 0, 0, 0, 3'd0, 12'h000, 12'd0,   4'd0, 1, 0, 12'd0);
        for (int i = 1; i <= 17; i++) begin
            step("sat",     0, 0, 0, 0, 0, 0, 3'd0, 12'h000, 12'(i),
                 (i >= 15) ? 4'd15 : 4'(i), 1, 0, 12'd0);
        end
        step("abs22",       0, 0, 0, 0, 1, 1, 3'd6, 12'd22,  12'd22,  4'd15, 1, 0, 12'd17);
        step("stall_br",    0, 0, 1, 0, 1, 1, 3'd7, 12'd100, 12'd22,  4'd15, 1, 0, 12'd17);
        step("abs100",      0, 0, 0, 0, 1, 1, 3'd7, 12'd100, 12'd100, 4'd15, 1, 0, 12'd22);
        step("reset_mid",   1, 0, 0, 0, 1, 1, 3'd1, 12'd200, 12'd0,   4'd0, 0, 0, 12'd0);
        step("idle_after",  0, 0, 0, 0, 0, 0, 3'd0, 12'h000, 12'd0,   4'd0, 0, 0, 12'd0);
        repeat (2) @(posedge Clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL timeout: run did not complete, got stuck want finished");
            $fatal(1, "timeout");
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the core's fetch path, and the consumer end of the branch-target lookup table.
- Drives a 3-bit index to the LUT and receives the D-bit target back.
- Applies the target as an absolute jump or a PC-relative (two's-complement) offset.
- Owns the start/run/halt handshake with the test harness.
- Counts retired (non-stalled) cycles.

Parameters:
D, 12, PC and target width in bits
START_PC, 0, PC value loaded when a run begins
CNT_W, 16, width of the retired-cycle counter

Ports:
Clk  input  1  single clock, all state updates on rising edge
Reset  input  1  synchronous, active-high
Start  input  1  one-cycle pulse; begins a run from IDLE or HALT
Stall  input  1  hold PC and counter this cycle (RUN only)
Halt_req  input  1  current instruction is the halt; finish the run
Br_en  input  1  take a branch this cycle
Br_abs  input  1  1 = Target is absolute PC; 0 = Target is a signed offset
Br_idx  input  3  branch-target selector from the decoder
Lut_idx  output  3  index driven to the target LUT
Target  input  D  target returned by the LUT (two's complement when relative)
PC  output  D  current program counter
Running  output  1  high while in RUN
Done  output  1  high while in HALT
Cycles  output  CNT_W  retired-cycle count for the last or current run

Behaviour:
- Reset: state IDLE, PC=START_PC, Cycles=0, Running=0, Done=0. Reset overrides every other input, including mid-run.
- Lut_idx = Br_idx, purely combinational. Target is sampled in the same cycle; the LUT is combinational, so there is no added latency.
- States: IDLE, RUN, HALT. Running and Done are registered, decoded from state.
- IDLE:
  - Start=1: next state RUN, PC<=START_PC, Cycles<=0.
  - Otherwise everything is held.
- RUN, evaluated in priority order:
  - Stall=1: hold PC and Cycles. Halt_req and Br_en are ignored this cycle.
  - Halt_req=1: next state HALT, PC held, Cycles+1.
  - Br_en=1 and Br_abs=1: PC<=Target, Cycles+1.
  - Br_en=1 and Br_abs=0: PC<=PC+Target, modulo 2^D, Cycles+1.
  - Otherwise: PC<=PC+1, modulo 2^D, Cycles+1.
- RUN also ignores Start.
- HALT:
  - PC and Cycles are held; Done=1.
  - Start=1: next state RUN, PC<=START_PC, Cycles<=0. Done drops on the next cycle.
- Arithmetic:
  - Relative add is D-bit with the carry discarded, e.g. PC=4 with Target=0xFFF (-1) gives 3, and PC=0 with Target=-5 gives 0xFFB.
  - PC+1 at 0xFFF wraps to 0.
- Cycles saturates at all-ones and does not wrap.
- Latency: the PC update is visible one cycle after the qualifying edge. Done rises one cycle after Halt_req is accepted.

Optional Feature:
LAST_BR_EN
- Defined:
  - Adds output Last_br_pc [D-1:0].
  - On every accepted taken branch in RUN, it captures the pre-branch PC.
  - Reset and Start clear it to 0; stalled cycles do not update it.
- Undefined: the port and register are absent; all other behaviour is identical.

Decomposition:
- Package pc_pkg holds:
  - the state enum (IDLE, RUN, HALT);
  - the default D and START_PC localparams;
  - a shared LUT index width constant (3).
- No sub-module is required; the design is a single FSM plus the PC datapath.
- The existing branch-target LUT is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset then Start: PC=0, Running=1 one cycle after Start. After 3 plain cycles, PC=3 and Cycles=3.
- Relative back-branch: PC=40, Br_en=1, Br_abs=0, Target=-30 gives PC=10. At PC=4 with Target=0xFFF, the next PC is 3.
- Absolute and wrap:
  - Br_abs=1, Target=346 gives PC=346.
  - PC=0xFFF with no branch gives PC=0.
  - PC=0 with relative Target=-5 gives 0xFFB.
- Priorities:
  - Stall with Br_en and Halt_req all high: PC and Cycles unchanged.
  - Next cycle, Halt_req with Br_en: HALT, PC unchanged, Done=1 the following cycle.
- Restart and reset:
  - Start while in HALT: PC=START_PC, Cycles=0, Done=0.
  - Reset asserted mid-RUN at PC=100: IDLE, PC=0, Cycles=0 on the next edge.
- With LAST_BR_EN defined: a branch from PC=22 gives Last_br_pc=22. A stalled branch cycle leaves it unchanged.
